eeprom_req_arbiter: RTL and testbench
=====================================

// Module: eeprom_req_arbiter
// PURPOSE
//   Shares one eeprom_top I2C EEPROM master between NUM_REQ independent requesters.
//   - Round-robin arbitration; one EEPROM transaction in flight at a time.
//   - Generates the newd pulse, waits for done, returns rdata/status to the winner.
//   - Sits between the system-side clients and the eeprom_top newd/wr/addr/wdata/rdata/done pins.
// PARAMETERS
//   NUM_REQ        2     number of requesters, legal range 1..8
//   NEWD_CYCLES    2     cycles ee_newd is held high per transaction (>=1)
//   TIMEOUT_CYCLES 4096  WAIT-state watchdog limit (used only with EE_ARB_TIMEOUT_EN)
// PORTS
//   clk        in   1          system clock; all logic on rising edge
//   rst        in   1          synchronous, active-high reset
//   req        in   NUM_REQ    per-requester request level; hold until own rsp_valid
//   req_wr     in   NUM_REQ    per-requester 1=write, 0=read
//   req_addr   in   7*NUM_REQ  per-requester 7-bit device address, requester i at [7i+6:7i]
//   req_wdata  in   8*NUM_REQ  per-requester write data, requester i at [8i+7:8i]
//   gnt        out  NUM_REQ    one-hot grant, high from ISSUE through RESP inclusive
//   rsp_valid  out  NUM_REQ    one-cycle completion pulse to the granted requester
//   rsp_rdata  out  8          read data, valid while any rsp_valid bit is high
//   rsp_err    out  1          timeout flag, valid with rsp_valid
//   ee_newd    out  1          to eeprom_top newd
//   ee_wr      out  1          to eeprom_top wr
//   ee_addr    out  7          to eeprom_top addr
//   ee_wdata   out  8          to eeprom_top wdata
//   ee_rdata   in   8          from eeprom_top rdata
//   ee_done    in   1          from eeprom_top done (level)
// BEHAVIOUR
//   Reset values: all outputs 0, state=IDLE, rr pointer=0, counters=0.
//   Reset mid-operation: abort immediately, ee_newd low the cycle after rst.
//   - No rsp_valid is issued for the aborted request.
//   FSM states:
//   - IDLE: if |req, pick first set bit scanning from pointer upward (wraps mod NUM_REQ).
//     Latch index, wr, addr, wdata into ee_* regs; assert gnt; -> ISSUE.
//   - ISSUE: ee_newd=1 for exactly NEWD_CYCLES cycles, then -> WAIT.
//     ee_wr/ee_addr/ee_wdata stay stable from ISSUE entry until return to IDLE.
//   - WAIT: on ee_done==1 capture ee_rdata -> RESP.
//     Done is sampled only in WAIT, so stale done during ISSUE is ignored.
//   - RESP: rsp_valid[idx]=1 for exactly one cycle; rsp_rdata=captured data.
//     Read data is forwarded on writes too; the requester ignores it.
//     Pointer <= (idx+1) mod NUM_REQ -> DRAIN.
//   - DRAIN: gnt=0; wait for ee_done==0 -> IDLE.
//     Prevents a held-high done from completing the next transaction.
//   Latency: req high in IDLE at edge t -> gnt and ee_newd high after edge t+1.
//   - rsp_valid follows one cycle after ee_done is sampled high in WAIT.
//   Requester dropping req after grant: ignored, transaction completes, rsp_valid still pulses.
//   Simultaneous requests: round-robin from pointer. A requester holding req continuously
//   is re-granted only after every other pending requester has been served once.
//   NUM_REQ==1: pointer is constant 0; no arbitration logic needed.
//   Index/pointer width: $clog2(NUM_REQ), minimum 1 bit.
// CONFIGURATION
//   EE_ARB_TIMEOUT_EN defined:
//   - WAIT counts cycles; when count reaches TIMEOUT_CYCLES-1 without ee_done -> RESP.
//     In that case rsp_err=1 and rsp_rdata=8'h00.
//   - Counter clears on every WAIT entry.
//   - DRAIN is then skipped if ee_done==0.
//   EE_ARB_TIMEOUT_EN undefined:
//   - WAIT has no limit; rsp_err is tied 0 and the port remains present.
// TESTING
//   1 Write: req[0], wr=1, addr=7'h50, wdata=8'hAA, eeprom model ACKs
//     -> ee_newd high 2 cycles, ee_wr=1, ee_addr=7'h50, ee_wdata=8'hAA,
//        one rsp_valid[0] pulse, rsp_err=0.
//   2 Read-back: req[1], wr=0, addr=7'h50 after test 1 -> rsp_valid[1] with rsp_rdata=8'hAA.
//   3 Contention: req=2'b11 held, same cycle after reset
//     -> grants in order 0,1,0,1; no back-to-back double grant.
//   4 Stale done: model holds ee_done high 50 cycles after completion while req[1] is pending
//     -> exactly one rsp_valid per transaction; req[1] issues only after done falls.
//   5 Reset in WAIT: assert rst for 1 cycle mid-transaction
//     -> next cycle ee_newd=0, gnt=0, rsp_valid=0, pointer=0; a new req[0] then completes normally.
//   6 (EE_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64) ee_done stuck 0
//     -> rsp_valid[0] with rsp_err=1, rsp_rdata=8'h00, 64 cycles after WAIT entry; FSM back in IDLE.

Source files
------------

// File: rtl/eeprom_req_arbiter_if.sv
// Bundle of client-side request/response and eeprom_top pin signals for the arbiter.
// slave: the arbiter itself. master: whoever drives requests and models the EEPROM.
// Requester i's fields sit at req_addr[7i+6:7i] and req_wdata[8i+7:8i].
interface eeprom_req_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_wr;
  logic [7*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [7:0]           rsp_rdata;
  logic                 rsp_err;
  logic                 ee_newd;
  logic                 ee_wr;
  logic [6:0]           ee_addr;
  logic [7:0]           ee_wdata;
  logic [7:0]           ee_rdata;
  logic                 ee_done;

  modport slave (
    input  req, req_wr, req_addr, req_wdata, ee_rdata, ee_done,
    output gnt, rsp_valid, rsp_rdata, rsp_err, ee_newd, ee_wr, ee_addr, ee_wdata
  );

  modport master (
    output req, req_wr, req_addr, req_wdata, ee_rdata, ee_done,
    input  gnt, rsp_valid, rsp_rdata, rsp_err, ee_newd, ee_wr, ee_addr, ee_wdata
  );
endinterface

// File: rtl/eeprom_req_arbiter.sv
// Round-robin share of one eeprom_top I2C master among NUM_REQ requesters, one transaction at a time.
// Latency: gnt/ee_newd rise one edge after req is sampled in IDLE; rsp_valid one edge after ee_done in WAIT.
// Backpressure: requesters hold req until their rsp_valid; optional WAIT watchdog under EE_ARB_TIMEOUT_EN.
module eeprom_req_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int NEWD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  eeprom_req_arbiter_if.slave bus
);

  localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CMAX = (TIMEOUT_CYCLES > NEWD_CYCLES) ? TIMEOUT_CYCLES : NEWD_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t             state_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      idx_q;
  logic [CW-1:0]      cnt_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [7:0]         rsp_rdata_q;
  logic               ee_newd_q;
  logic               ee_wr_q;
  logic [6:0]         ee_addr_q;
  logic [7:0]         ee_wdata_q;
`ifdef EE_ARB_TIMEOUT_EN
  logic               rsp_err_q;
`endif

  logic               pick_vld_d;
  logic [IW-1:0]      pick_idx_d;
  logic [IW-1:0]      ptr_d;
  logic [NUM_REQ-1:0] pick_oh_d;
  logic [NUM_REQ-1:0] idx_oh_d;
  logic               sel_wr_d;
  logic [6:0]         sel_addr_d;
  logic [7:0]         sel_wdata_d;

  // Round-robin pick: first pending requester at or above the pointer, wrapping.
  always_comb begin
    int            j;
    logic [IW-1:0] jj;
    pick_vld_d = 1'b0;
    pick_idx_d = '0;
    j          = 0;
    jj         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IW'(j);
      if (!pick_vld_d && bus.req[jj]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = jj;
      end
    end
  end

  // Winner's fields and one-hot vectors, plus the pointer value after serving idx_q.
  always_comb begin
    sel_wr_d    = 1'b0;
    sel_addr_d  = '0;
    sel_wdata_d = '0;
    pick_oh_d   = '0;
    idx_oh_d    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_oh_d[i] = (pick_idx_d == IW'(i));
      idx_oh_d[i]  = (idx_q == IW'(i));
      if (pick_idx_d == IW'(i)) begin
        sel_wr_d    = bus.req_wr[i];
        sel_addr_d  = bus.req_addr[7*i +: 7];
        sel_wdata_d = bus.req_wdata[8*i +: 8];
      end
    end
    ptr_d = (int'(idx_q) >= NUM_REQ - 1) ? '0 : idx_q + 1'b1;
  end

  // Transaction FSM with registered grant, EEPROM pins and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      ee_newd_q   <= 1'b0;
      ee_wr_q     <= 1'b0;
      ee_addr_q   <= '0;
      ee_wdata_q  <= '0;
`ifdef EE_ARB_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (pick_vld_d) begin
            idx_q      <= pick_idx_d;
            ee_wr_q    <= sel_wr_d;
            ee_addr_q  <= sel_addr_d;
            ee_wdata_q <= sel_wdata_d;
            gnt_q      <= pick_oh_d;
            ee_newd_q  <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cnt_q == CW'(NEWD_CYCLES - 1)) begin
            ee_newd_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= S_WAIT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.ee_done) begin
            rsp_rdata_q <= bus.ee_rdata;
            rsp_valid_q <= idx_oh_d;
`ifdef EE_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state_q     <= S_RESP;
          end
`ifdef EE_ARB_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            rsp_rdata_q <= 8'h00;
            rsp_valid_q <= idx_oh_d;
            rsp_err_q   <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        S_RESP: begin
          gnt_q <= '0;
          ptr_q <= ptr_d;
`ifdef EE_ARB_TIMEOUT_EN
          // A timed-out transaction normally leaves done low, so nothing to drain.
          state_q <= bus.ee_done ? S_DRAIN : S_IDLE;
`else
          state_q <= S_DRAIN;
`endif
        end
        S_DRAIN: begin
          // A done held high from the last transaction must not complete the next one.
          if (!bus.ee_done) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.ee_newd   = ee_newd_q;
  assign bus.ee_wr     = ee_wr_q;
  assign bus.ee_addr   = ee_addr_q;
  assign bus.ee_wdata  = ee_wdata_q;
`ifdef EE_ARB_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_eeprom_req_arbiter.sv
// Bench for eeprom_req_arbiter: EEPROM model, two requesters, response scoreboard.
// Expected responses are queued as requests are raised and popped on each rsp_valid.
// Timeout scenario runs only when EE_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_eeprom_req_arbiter;

  localparam int NUM_REQ     = 2;
  localparam int NEWD_CYCLES = 2;
`ifdef EE_ARB_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = 64;
`else
  localparam int TIMEOUT_CYCLES = 4096;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eeprom_req_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

  eeprom_req_arbiter #(
    .NUM_REQ(NUM_REQ),
    .NEWD_CYCLES(NEWD_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         idx;
    bit         has_data;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   total   = 0;
  int   bad     = 0;
  int   rsp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, want);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (|bus.rsp_valid)) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_idx", 32'(bus.rsp_valid), 32'd1 << e.idx);
        chk("rsp_gnt", 32'(bus.gnt), 32'd1 << e.idx);
        if (e.has_data) chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
      rsp_cnt++;
    end
  end

  // ---------------- EEPROM model ----------------
  logic [7:0] mem [0:127];
  int         done_hold  = 1;
  bit         mute       = 1'b0;
  bit         stale_newd = 1'b0;
  logic       cap_wr;
  logic [6:0] cap_addr;
  logic [7:0] cap_wdata;
  int         cap_len;

  initial begin
    bus.ee_done  = 1'b0;
    bus.ee_rdata = 8'h00;
    cap_wr = 1'b0; cap_addr = '0; cap_wdata = '0; cap_len = 0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && bus.ee_newd) begin
        cap_wr    = bus.ee_wr;
        cap_addr  = bus.ee_addr;
        cap_wdata = bus.ee_wdata;
        cap_len   = 0;
        while (bus.ee_newd && cap_len < 20) begin
          cap_len++;
          @(negedge clk);
        end
        chk("newd_len", 32'(cap_len), 32'(NEWD_CYCLES));
        if (!mute) begin
          repeat (3) @(negedge clk);
          chk("ee_stable", 32'({bus.ee_wr, bus.ee_addr, bus.ee_wdata}),
              32'({cap_wr, cap_addr, cap_wdata}));
          if (cap_wr) mem[cap_addr] = cap_wdata;
          bus.ee_rdata = mem[cap_addr];
          bus.ee_done  = 1'b1;
          repeat (done_hold) begin
            @(negedge clk);
            if (bus.ee_newd) stale_newd = 1'b1;
          end
          bus.ee_done = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int i, input logic wr, input logic [6:0] addr, input logic [7:0] wdata);
    bus.req[i]             = 1'b1;
    bus.req_wr[i]          = wr;
    bus.req_addr[7*i +: 7] = addr;
    bus.req_wdata[8*i +: 8] = wdata;
  endtask

  task automatic push(input int idx, input bit has_data, input logic [7:0] rdata, input logic err);
    exp_t e;
    e.idx = idx; e.has_data = has_data; e.rdata = rdata; e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_rsp(input int n, input string tag);
    int c = 0;
    while (rsp_cnt < n && c < 400) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk(tag, 32'(rsp_cnt >= n), 32'd1);
  endtask

  task automatic wait_newd_fall(input string tag);
    int c    = 0;
    bit seen = 1'b0;
    while (!bus.ee_newd && c < 50) begin @(negedge clk); c++; end
    if (bus.ee_newd) seen = 1'b1;
    while (bus.ee_newd && c < 100) begin @(negedge clk); c++; end
    chk(tag, 32'(seen && !bus.ee_newd), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst           = 1'b1;
    bus.req       = '0;
    bus.req_wr    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_gnt",  32'(bus.gnt), 32'd0);
    chk("rst_rspv", 32'(bus.rsp_valid), 32'd0);
    chk("rst_newd", 32'(bus.ee_newd), 32'd0);
    chk("rst_ee",   32'({bus.ee_wr, bus.ee_addr, bus.ee_wdata}), 32'd0);
    chk("rst_rsp",  32'({bus.rsp_rdata, bus.rsp_err}), 32'd0);

    // contention straight out of reset: 0,1,0,1
    rst = 1'b0;
    set_req(0, 1'b1, 7'h01, 8'h11);
    set_req(1, 1'b0, 7'h01, 8'h00);
    push(0, 1'b0, 8'h00, 1'b0);
    push(1, 1'b1, 8'h11, 1'b0);
    push(0, 1'b0, 8'h00, 1'b0);
    push(1, 1'b1, 8'h11, 1'b0);
    wait_rsp(4, "t3_wait");
    bus.req = '0;

    // single write
    set_req(0, 1'b1, 7'h50, 8'hAA);
    push(0, 1'b0, 8'h00, 1'b0);
    wait_rsp(5, "t1_wait");
    bus.req[0] = 1'b0;
    chk("t1_wr",    32'(cap_wr), 32'd1);
    chk("t1_addr",  32'(cap_addr), 32'h50);
    chk("t1_wdata", 32'(cap_wdata), 32'hAA);

    // read back from the other requester
    set_req(1, 1'b0, 7'h50, 8'h00);
    push(1, 1'b1, 8'hAA, 1'b0);
    wait_rsp(6, "t2_wait");
    bus.req[1] = 1'b0;
    chk("t2_addr", 32'(cap_addr), 32'h50);

    // stale done held 50 cycles while requester 1 waits
    done_hold  = 50;
    stale_newd = 1'b0;
    set_req(0, 1'b1, 7'h20, 8'h5A);
    set_req(1, 1'b0, 7'h20, 8'h00);
    push(0, 1'b0, 8'h00, 1'b0);
    push(1, 1'b1, 8'h5A, 1'b0);
    wait_rsp(7, "t4_wait0");
    bus.req[0] = 1'b0;
    wait_rsp(8, "t4_wait1");
    bus.req[1] = 1'b0;
    chk("t4_stale_newd", 32'(stale_newd), 32'd0);
    done_hold = 1;

    // leave the pointer at 1 before the reset test
    set_req(0, 1'b0, 7'h50, 8'h00);
    push(0, 1'b1, 8'hAA, 1'b0);
    wait_rsp(9, "ptr_wait");
    bus.req[0] = 1'b0;

    // reset while waiting on the EEPROM
    mute = 1'b1;
    set_req(1, 1'b0, 7'h50, 8'h00);
    wait_newd_fall("t5_issue");
    repeat (3) @(negedge clk);
    rst        = 1'b1;
    bus.req[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_newd", 32'(bus.ee_newd), 32'd0);
    chk("t5_gnt",  32'(bus.gnt), 32'd0);
    chk("t5_rspv", 32'(bus.rsp_valid), 32'd0);
    mute = 1'b0;
    // pointer back at 0: requester 0 wins a tie
    set_req(0, 1'b0, 7'h50, 8'h00);
    set_req(1, 1'b0, 7'h01, 8'h00);
    push(0, 1'b1, 8'hAA, 1'b0);
    push(1, 1'b1, 8'h11, 1'b0);
    wait_rsp(10, "t5_wait0");
    bus.req[0] = 1'b0;
    wait_rsp(11, "t5_wait1");
    bus.req[1] = 1'b0;

`ifdef EE_ARB_TIMEOUT_EN
    // done stuck low: watchdog completes with err
    mute = 1'b1;
    set_req(0, 1'b0, 7'h33, 8'h00);
    push(0, 1'b1, 8'h00, 1'b1);
    wait_newd_fall("t6_issue");
    n = 0;
    while (!bus.rsp_valid[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_latency", 32'(n), 32'(TIMEOUT_CYCLES));
    bus.req[0] = 1'b0;
    wait_rsp(12, "t6_wait");
    mute = 1'b0;
    set_req(0, 1'b0, 7'h50, 8'h00);
    push(0, 1'b1, 8'hAA, 1'b0);
    wait_rsp(13, "t6_after");
    bus.req[0] = 1'b0;
`else
    n = 0;
`endif

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
